// File: rtl/uart_wb_tx_feeder.sv
// uart_wb_tx_feeder
// Buffers upstream bytes in a small FIFO. Drains them into a 16550-style UART
// over a Wishbone master port. Each byte costs one LSR poll and one THR write.
// Optional macro UART_WB_TIMEOUT_EN adds an ack watchdog and a sticky err flag.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   in_valid_i/in_data_i  upstream byte handshake input
//   in_ready_o            FIFO can accept a byte
//   wb_*                  Wishbone master (address, data out/in, we, stb, cyc, sel, ack)
//   fifo_count_o          bytes currently buffered
//   busy_o                FSM not idle or FIFO non-empty
//   err_o                 sticky ack-timeout flag (0 when the timeout is disabled)
//
// state   | meaning
// S_IDLE  | bus idle; start an LSR poll when the FIFO holds data
// S_POLL  | LSR read in flight; THRE decides write or retry
// S_WRITE | one idle bus cycle, then THR write of the FIFO head
`timescale 1ns/1ps
module uart_wb_tx_feeder #(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [2:0] LSR_ADDR    = 3'd5,
  parameter logic [2:0] THR_ADDR    = 3'd0,
  parameter int         ACK_TIMEOUT = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          in_valid_i,
  input  logic [7:0]                    in_data_i,
  output logic                          in_ready_o,
  output logic [2:0]                    wb_address_o,
  output logic [7:0]                    wb_data_out_o,
  input  logic [7:0]                    wb_data_in_i,
  output logic                          wb_we_o,
  output logic                          wb_stb_o,
  output logic                          wb_cyc_o,
  output logic [3:0]                    wb_sel_o,
  input  logic                          wb_ack_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_POLL, S_WRITE} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  state_t     state_q;
  logic       cyc_q, stb_q, we_q;
  logic [2:0] addr_q;
  logic [7:0] dout_q;
  logic       ack_seen;
  logic       timeout;

  // Only THRE matters in the LSR; the remaining bits are read but unused.
  logic unused_lsr_bits;
  assign unused_lsr_bits = ^{wb_data_in_i[7:6], wb_data_in_i[4:0]};

  assign in_ready_o = (count_q < CW'(FIFO_DEPTH));
  assign push       = in_valid_i & in_ready_o;
  assign ack_seen   = cyc_q & wb_ack_i;
  assign pop        = (state_q == S_WRITE) & ack_seen;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

`ifdef UART_WB_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] wait_q;
  logic          err_q;

  // The counter sits at zero whenever cyc is low, so it starts from zero on every bus cycle.
  assign timeout = cyc_q & ~wb_ack_i & (wait_q == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!cyc_q)         wait_q <= '0;
      else if (!wb_ack_i) wait_q <= wait_q + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 3'd0;
      dout_q  <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_POLL;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= LSR_ADDR;
          end
        end
        S_POLL: begin
          if (ack_seen) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= wb_data_in_i[5] ? S_WRITE : S_IDLE;
          end else if (timeout) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WRITE: begin
          // The first WRITE cycle keeps the bus idle to separate it from the poll.
          // The head is latched once, so later pushes cannot disturb the data.
          if (!cyc_q) begin
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            we_q   <= 1'b1;
            addr_q <= THR_ADDR;
            dout_q <= mem_q[rd_ptr_q];
          end else if (ack_seen || timeout) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_we_o       = we_q;
  assign wb_address_o  = addr_q;
  assign wb_data_out_o = dout_q;
  assign wb_sel_o      = 4'b0001;
  assign fifo_count_o  = count_q;
  assign busy_o        = (state_q != S_IDLE) | (count_q != '0);

endmodule
